// File: rtl/hci_package.sv
// Shared HCI parameters and types for the memory-side bank responder.
package hci_package;

    localparam int DEFAULT_AW = 32;
    localparam int DEFAULT_DW = 32;
    localparam int DEFAULT_BW = 8;
    localparam int DEFAULT_UW = 4;

    // Widest word the all-ones fill constant can cover; users slice what they need.
    localparam int HCI_MAX_W = 1024;

    typedef enum logic {
        READY = 1'b0,
        TS_WB = 1'b1
    } hci_bank_state_e;

    localparam logic [HCI_MAX_W-1:0] HCI_TS_FILL = '1;

endpackage

// File: rtl/hci_mem_bank_storage.sv
// Byte-enabled word array with one write port and one registered read port.
module hci_mem_bank_storage #(
    parameter int DW    = 32,
    parameter int BW    = 8,
    parameter int UW    = 4,
    parameter int DEPTH = 256,
    parameter int IDXW  = $clog2(DEPTH),
    parameter int SW    = DW + UW,
    parameter int NL    = DW / BW
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            we_i,
    input  logic [IDXW-1:0] widx_i,
    input  logic [NL-1:0]   wbe_i,
    input  logic            wuen_i,
    input  logic [SW-1:0]   wdata_i,
    input  logic            re_i,
    input  logic [IDXW-1:0] ridx_i,
    output logic [SW-1:0]   rdata_o
);

    logic [SW-1:0] mem_q [DEPTH];
    logic [SW-1:0] mem_d [DEPTH];
    logic [SW-1:0] rdata_q, rdata_d;
    logic [SW-1:0] wmask;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wmask   = '0;
        mem_d   = mem_q;
        rdata_d = rdata_q;
        for (int b = 0; b < DW; b++) wmask[b] = wbe_i[b / BW];
        for (int b = DW; b < SW; b++) wmask[b] = wuen_i;
        if (we_i) mem_d[widx_i] = (mem_q[widx_i] & ~wmask) | (wdata_i & wmask);
        // The read port samples the pre-write content, which is what the response must carry.
        if (re_i) rdata_d = mem_q[ridx_i];
    end

    // NOTE: the array itself is reset because the bank must read 0 everywhere after reset; a plain RAM macro would not.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q   <= '{default: '0};
            rdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples values from before this edge.
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/hci_mem_bank_responder.sv
// Single TCDM bank behind one HCI memory port: byte-enabled read/write, test-and-set, one-cycle response.
module hci_mem_bank_responder
    import hci_package::*;
#(
    parameter int AW    = DEFAULT_AW,
    parameter int DW    = DEFAULT_DW,
    parameter int BW    = DEFAULT_BW,
    parameter int UW    = DEFAULT_UW,
    parameter int IW    = 8,
    parameter int DEPTH = 256,
    parameter int UPW   = (UW > 0) ? UW : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    output logic             gnt_o,
    input  logic [AW-1:0]    add_i,
    input  logic             wen_i,
    input  logic [DW/BW-1:0] be_i,
    input  logic [DW-1:0]    data_i,
    input  logic [UPW-1:0]   user_i,
    input  logic [IW-1:0]    id_i,
    input  logic             ts_set_i,
    output logic             r_valid_o,
    output logic [DW-1:0]    r_data_o,
    output logic [UPW-1:0]   r_user_o,
    output logic [IW-1:0]    r_id_o
);

    localparam int IDXW = $clog2(DEPTH);
    localparam int SW   = DW + UW;
    localparam int NL   = DW / BW;

    hci_bank_state_e state_q, state_d;
    logic [IDXW-1:0] ts_idx_q, ts_idx_d;
    logic            r_valid_q, r_valid_d;
    logic [IW-1:0]   r_id_q, r_id_d;

    logic            grant;
    logic [IDXW-1:0] req_idx;
    logic [SW-1:0]   req_word;
    logic [SW-1:0]   rdata_word;
    logic            st_we;
    logic [IDXW-1:0] st_widx;
    logic [NL-1:0]   st_wbe;
    logic            st_wuen;
    logic [SW-1:0]   st_wdata;
    logic            unused_add;

    assign grant      = (state_q == READY) && req_i;
    assign gnt_o      = grant;
    assign req_idx    = add_i[IDXW+1:2];
    assign unused_add = ^add_i;

    generate
        if (UW > 0) begin : g_user
            assign req_word = {user_i, data_i};
            assign r_user_o = rdata_word[SW-1:DW];
        end else begin : g_no_user
            logic unused_user;
            assign unused_user = ^user_i;
            assign req_word    = data_i;
            assign r_user_o    = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        ts_idx_d  = ts_idx_q;
        r_valid_d = grant;
        r_id_d    = grant ? id_i : r_id_q;
        unique case (state_q)
            READY: begin
                if (grant && wen_i && ts_set_i) begin
                    state_d  = TS_WB;
                    ts_idx_d = req_idx;
                end
            end
            TS_WB:   state_d = READY;
            default: state_d = READY;
        endcase
    end

    // The writeback cycle owns the write port; grant is 0 then, so there is no conflict.
    always_comb begin
        st_we    = grant && !wen_i;
        st_widx  = req_idx;
        st_wbe   = be_i;
        st_wuen  = |be_i;
        st_wdata = req_word;
        if (state_q == TS_WB) begin
            st_we    = 1'b1;
            st_widx  = ts_idx_q;
            st_wbe   = '1;
            st_wuen  = 1'b1;
            st_wdata = HCI_TS_FILL[SW-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= READY;
            ts_idx_q  <= '0;
            r_valid_q <= 1'b0;
            r_id_q    <= '0;
        end else begin
            state_q   <= state_d;
            ts_idx_q  <= ts_idx_d;
            r_valid_q <= r_valid_d;
            r_id_q    <= r_id_d;
        end
    end

    hci_mem_bank_storage #(
        .DW    (DW),
        .BW    (BW),
        .UW    (UW),
        .DEPTH (DEPTH)
    ) i_storage (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (st_we),
        .widx_i  (st_widx),
        .wbe_i   (st_wbe),
        .wuen_i  (st_wuen),
        .wdata_i (st_wdata),
        .re_i    (grant),
        .ridx_i  (req_idx),
        .rdata_o (rdata_word)
    );

    assign r_valid_o = r_valid_q;
    assign r_id_o    = r_id_q;
    assign r_data_o  = rdata_word[DW-1:0];

endmodule

// File: tb/tb_hci_mem_bank_responder.sv
// Scoreboard bench for hci_mem_bank_responder: the driver queues expected responses, the monitor checks them.
module tb_hci_mem_bank_responder;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic        gnt_o;
    logic [31:0] add_i = '0;
    logic        wen_i = 1'b1;
    logic [3:0]  be_i = '0;
    logic [31:0] data_i = '0;
    logic [3:0]  user_i = '0;
    logic [7:0]  id_i = '0;
    logic        ts_set_i = 1'b0;
    logic        r_valid_o;
    logic [31:0] r_data_o;
    logic [3:0]  r_user_o;
    logic [7:0]  r_id_o;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic [3:0]  user;
        logic [7:0]  id;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    always #5 clk_i = ~clk_i;

    hci_mem_bank_responder #(
        .AW(32), .DW(32), .BW(8), .UW(4), .IW(8), .DEPTH(256)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req_i),
        .gnt_o     (gnt_o),
        .add_i     (add_i),
        .wen_i     (wen_i),
        .be_i      (be_i),
        .data_i    (data_i),
        .user_i    (user_i),
        .id_i      (id_i),
        .ts_set_i  (ts_set_i),
        .r_valid_o (r_valid_o),
        .r_data_o  (r_data_o),
        .r_user_o  (r_user_o),
        .r_id_o    (r_id_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every response pulse must match the oldest queued expectation.
    always @(negedge clk_i) begin
        if (rst_ni && r_valid_o) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL unexpected_rsp: got response id 0x%0h, expected none", r_id_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_data"}, 64'(r_data_o), 64'(e.data));
                check({e.name, "_user"}, 64'(r_user_o), 64'(e.user));
                check({e.name, "_id"},   64'(r_id_o),   64'(e.id));
            end
        end
    end

    task automatic drive(input logic [31:0] addr, input logic wen, input logic ts, input logic [3:0] be,
                         input logic [31:0] data, input logic [3:0] user, input logic [7:0] id);
        req_i    = 1'b1;
        add_i    = addr;
        wen_i    = wen;
        ts_set_i = ts;
        be_i     = be;
        data_i   = data;
        user_i   = user;
        id_i     = id;
    endtask

    // One granted access; the caller keeps back-to-back requests by calling again immediately.
    task automatic issue(input string name, input logic [31:0] addr, input logic wen, input logic ts,
                         input logic [3:0] be, input logic [31:0] data, input logic [3:0] user,
                         input logic [7:0] id, input logic [31:0] ed, input logic [3:0] eu);
        exp_t e;
        drive(addr, wen, ts, be, data, user, id);
        @(negedge clk_i);
        check({name, "_gnt"}, 64'(gnt_o), 64'd1);
        e.name = name;
        e.data = ed;
        e.user = eu;
        e.id   = id;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        req_i = 1'b0;
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_gnt"},    64'(gnt_o),     64'd0);
        check({name, "_rvalid"}, 64'(r_valid_o), 64'd0);
        check({name, "_rdata"},  64'(r_data_o),  64'd0);
        check({name, "_ruser"},  64'(r_user_o),  64'd0);
        check({name, "_rid"},    64'(r_id_o),    64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_outputs_zero("reset");
        #1 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Read after reset returns 0 with the echoed ID.
        issue("rd_idx5", 32'h14, 1'b1, 1'b0, 4'h0, 32'h0, 4'h0, 8'd3, 32'h0, 4'h0);
        idle(1);

        // Write then back-to-back read of the same word.
        issue("wr_10", 32'h10, 1'b0, 1'b0, 4'hF, 32'hDEADBEEF, 4'hA, 8'd1, 32'h0, 4'h0);
        issue("rd_10", 32'h10, 1'b1, 1'b0, 4'h0, 32'h0, 4'h0, 8'd2, 32'hDEADBEEF, 4'hA);
        idle(1);

        // Partial byte-enable write; the write response carries the old word.
        issue("wr_20_all", 32'h20, 1'b0, 1'b0, 4'hF, 32'hFFFFFFFF, 4'hF, 8'd4, 32'h0, 4'h0);
        issue("wr_20_be5", 32'h20, 1'b0, 1'b0, 4'b0101, 32'h00000000, 4'h0, 8'd5, 32'hFFFFFFFF, 4'hF);
        issue("rd_20", 32'h20, 1'b1, 1'b0, 4'h0, 32'h0, 4'h0, 8'd6, 32'hFF00FF00, 4'h0);
        idle(1);

        // Test-and-set: old value back, one stalled cycle, then all-ones.
        issue("wr_30", 32'h30, 1'b0, 1'b0, 4'hF, 32'h00000012, 4'h3, 8'd7, 32'h0, 4'h0);
        issue("ts_30", 32'h30, 1'b1, 1'b1, 4'h0, 32'h0, 4'h0, 8'd8, 32'h00000012, 4'h3);
        drive(32'h30, 1'b1, 1'b0, 4'h0, 32'h0, 4'h0, 8'd9);
        @(negedge clk_i);
        check("ts_wb_stall_gnt", 64'(gnt_o), 64'd0);
        @(posedge clk_i);
        #1;
        issue("rd_30_after_ts", 32'h30, 1'b1, 1'b0, 4'h0, 32'h0, 4'h0, 8'd9, 32'hFFFFFFFF, 4'hF);
        idle(1);

        // Address wrap modulo DEPTH words.
        issue("wr_04", 32'h0000_0004, 1'b0, 1'b0, 4'hF, 32'h000000A5, 4'h0, 8'd10, 32'h0, 4'h0);
        issue("rd_404", 32'h0000_0404, 1'b1, 1'b0, 4'h0, 32'h0, 4'h0, 8'd11, 32'h000000A5, 4'h0);
        idle(1);

        // Reset landing in the writeback cycle aborts it and clears the bank.
        issue("wr_40", 32'h40, 1'b0, 1'b0, 4'hF, 32'h00000055, 4'h0, 8'd12, 32'h0, 4'h0);
        issue("ts_40", 32'h40, 1'b1, 1'b1, 4'h0, 32'h0, 4'h0, 8'd13, 32'h00000055, 4'h0);
        req_i = 1'b0;
        @(negedge clk_i);
        #1 rst_ni = 1'b0;
        #1;
        check_outputs_zero("rst_in_tswb");
        check("rst_sb_empty", 64'(sb.size()), 64'd0);
        @(negedge clk_i);
        #1 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        check("post_rst_idle_gnt", 64'(gnt_o), 64'd0);
        @(posedge clk_i);
        #1;
        issue("rd_40_after_rst", 32'h40, 1'b1, 1'b0, 4'h0, 32'h0, 4'h0, 8'd14, 32'h0, 4'h0);
        idle(3);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
